// File: rtl/ring_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_arb_pkg
// Description : Shared types, defaults and ring helper for ring_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ring_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int N_DEF        = 4;
    localparam int MAX_HOLD_DEF = 8;

    // Rotates the low `width` bits of vec left by one; callers narrow the result.
    function automatic logic [63:0] rotl1(input logic [63:0] vec, input int width);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < 63; i++) begin
            if (i + 1 < width) begin
                res[i+1] = vec[i];
            end
        end
        res[0] = vec[6'(width - 1)];
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick via doubled-vector mask scan.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import ring_arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ring,
    output logic [N-1:0] pick,
    output logic         any
);

    logic [N-1:0]   w_mask_lo;
    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_low;

    // Lower copy keeps only positions at or above the ring bit; the upper copy
    // supplies the wrapped-around candidates, so the lowest set bit is the winner.
    assign w_mask_lo = ~(ring - N'(1));
    assign w_dbl     = {req, req} & {{N{1'b1}}, w_mask_lo};
    assign w_low     = w_dbl & (~w_dbl + (2*N)'(1));
    assign pick      = w_low[N-1:0] | w_low[2*N-1:N];
    assign any       = |req;

endmodule
`default_nettype wire

// File: rtl/ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ring_rr_arbiter
// Description : Round-robin arbiter with one-hot priority ring and hold timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         grant,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic [N-1:0]         ring,
    output logic                 timeout
);

    localparam int c_OW     = $clog2(N);
    localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(MAX_HOLD);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [N-1:0]        r_grant;
    logic                r_busy;
    logic [c_OW-1:0]     r_owner;
    logic [N-1:0]        r_ring;
    logic                r_timeout;
    logic [c_HOLD_W-1:0] r_hold;

    logic [N-1:0]        w_grant_nxt;
    logic                w_busy_nxt;
    logic [c_OW-1:0]     w_owner_nxt;
    logic [N-1:0]        w_ring_nxt;
    logic                w_timeout_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;

    logic [N-1:0]        w_pick;
    logic                w_any;
    logic [c_OW-1:0]     w_pick_idx;
    logic                w_release;
    logic                w_expire;
    logic [N-1:0]        w_owner_oh;
    logic [N-1:0]        w_ring_rot;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req  (req),
        .ring (r_ring),
        .pick (w_pick),
        .any  (w_any)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = c_OW'(i);
            end
        end
    end

    // Release wins over expiry so a same-edge done never produces a timeout.
    assign w_release  = (r_state == BUSY) && (done[r_owner] || !req[r_owner]);
    assign w_expire   = (r_state == BUSY) && !w_release && (r_hold == c_HOLD_LAST);
    assign w_owner_oh = N'(1) << r_owner;
    assign w_ring_rot = N'(rotl1(64'(w_owner_oh), N));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = BUSY;
            BUSY:    if (w_release || w_expire) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt   = r_grant;
        w_busy_nxt    = r_busy;
        w_owner_nxt   = r_owner;
        w_ring_nxt    = r_ring;
        w_timeout_nxt = 1'b0;
        w_hold_nxt    = r_hold;
        case (r_state)
            IDLE: begin
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                if (w_any) begin
                    w_grant_nxt = w_pick;
                    w_owner_nxt = w_pick_idx;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            BUSY: begin
                if (w_release || w_expire) begin
                    w_grant_nxt   = '0;
                    w_busy_nxt    = 1'b0;
                    w_ring_nxt    = w_ring_rot;
                    w_timeout_nxt = w_expire;
                end else if (r_hold != c_HOLD_MAX) begin
                    w_hold_nxt = r_hold + c_HOLD_W'(1);
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_owner   <= '0;
            r_ring    <= N'(1);
            r_timeout <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_grant   <= w_grant_nxt;
            r_busy    <= w_busy_nxt;
            r_owner   <= w_owner_nxt;
            r_ring    <= w_ring_nxt;
            r_timeout <= w_timeout_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    assign grant   = r_grant;
    assign busy    = r_busy;
    assign owner   = r_owner;
    assign ring    = r_ring;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_rr_arbiter
// Description : Directed and random checks of ring_rr_arbiter against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic         busy;
    logic [1:0]   owner;
    logic [N-1:0] ring;
    logic         timeout;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: owner and priority kept as plain integer indices.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_to;

    ring_rr_arbiter #(
        .N        (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .busy    (busy),
        .owner   (owner),
        .ring    (ring),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d, input bit rs);
        bit found;
        if (rs) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to  = 0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && r[(m_ptr + k) % N]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % N;
                end
            end
            if (found) begin
                m_busy = 1;
                m_hold = 0;
            end
        end else begin
            m_to = 0;
            if (d[m_owner] || !r[m_owner]) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end else if (m_hold == MH - 1) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
                m_to   = 1;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic check_model();
        chk("grant",   32'(grant),   m_busy ? (32'd1 << m_owner) : 32'd0);
        chk("busy",    32'(busy),    32'(m_busy));
        chk("owner",   32'(owner),   32'(m_owner));
        chk("ring",    32'(ring),    32'd1 << m_ptr);
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d, input bit rs);
        req   = r;
        done  = d;
        reset = rs;
        @(posedge clk);
        model_step(r, d, rs);
        #1;
        check_model();
    endtask

    initial begin
        int           rr_order[5];
        logic [N-1:0] rq;
        logic [N-1:0] dn;
        bit           rs;

        rr_order = '{0, 1, 2, 3, 0};
        req = '0; done = '0; reset = 1'b1;

        // Reset values
        cyc(4'b0000, 4'b0000, 1);
        cyc(4'b0000, 4'b0000, 1);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_ring",  32'(ring),  32'h1);

        // Reset priority
        cyc(4'b1010, 4'b0000, 0);
        chk("rp_grant", 32'(grant), 32'b0010);
        chk("rp_ring",  32'(ring),  32'b0001);
        cyc(4'b1010, 4'b0010, 0);
        chk("rp_rel_grant", 32'(grant), 32'h0);
        chk("rp_rel_ring",  32'(ring),  32'b0100);
        cyc(4'b1010, 4'b0000, 0);
        chk("rp_next", 32'(grant), 32'b1000);
        cyc(4'b0000, 4'b0000, 0);

        // Round-robin fairness with a grant-free gap each time
        for (int g = 0; g < 5; g++) begin
            cyc(4'b1111, 4'b0000, 0);
            chk("rr_order", 32'(owner), 32'(rr_order[g]));
            cyc(4'b1111, 4'b0000, 0);
            cyc(4'b1111, 4'(1 << rr_order[g]), 0);
            chk("rr_gap", 32'(grant), 32'h0);
        end

        // Timeout after exactly MH held cycles
        for (int k = 0; k < MH; k++) begin
            cyc(4'b0100, 4'b0000, 0);
            chk("to_hold", 32'(grant), 32'b0100);
        end
        cyc(4'b0100, 4'b0000, 0);
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_grant", 32'(grant),   32'h0);
        chk("to_ring",  32'(ring),    32'b1000);
        cyc(4'b0100, 4'b0000, 0);
        chk("to_regrant", 32'(grant),   32'b0100);
        chk("to_clear",   32'(timeout), 32'h0);

        // Release on the last allowed edge beats the timeout
        for (int k = 0; k < MH - 1; k++) cyc(4'b0100, 4'b0000, 0);
        cyc(4'b0100, 4'b0100, 0);
        chk("sim_timeout", 32'(timeout), 32'h0);
        chk("sim_grant",   32'(grant),   32'h0);

        // Foreign done and non-owner req changes, then owner drop
        cyc(4'b0100, 4'b0000, 0);
        cyc(4'b0100, 4'b0001, 0);
        chk("foreign_done", 32'(grant), 32'b0100);
        cyc(4'b0101, 4'b0001, 0);
        chk("foreign_req", 32'(grant), 32'b0100);
        cyc(4'b0001, 4'b0000, 0);
        chk("drop_grant", 32'(grant), 32'h0);
        cyc(4'b0001, 4'b0000, 0);
        cyc(4'b0000, 4'b0000, 0);

        // Reset mid-grant
        cyc(4'b0100, 4'b0000, 0);
        chk("mid_pre", 32'(grant), 32'b0100);
        cyc(4'b0100, 4'b0000, 1);
        chk("mid_grant",   32'(grant),   32'h0);
        chk("mid_ring",    32'(ring),    32'h1);
        chk("mid_timeout", 32'(timeout), 32'h0);
        chk("mid_busy",    32'(busy),    32'h0);

        // Random traffic with sticky requests so timeouts occur
        rq = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) rq = 4'($urandom_range(0, 15));
            dn = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rs = ($urandom_range(0, 99) == 0);
            cyc(rq, dn, rs);
            chk("onehot", 32'($countones(grant) <= 1), 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
